// File: rtl/riscv_pkg.sv
// Shared RV32I multicycle control definitions: FSM states, opcodes and datapath select encodings.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

endpackage

// File: rtl/imm_decoder.sv
// Opcode to immediate-format select for the immediate extender.
module imm_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] immsrc
);

  always_comb begin
    immsrc = IMM_I;
    case (op)
      OP_LW, OP_I: immsrc = IMM_I;
      OP_SW:       immsrc = IMM_S;
      OP_BEQ:      immsrc = IMM_B;
      OP_JAL:      immsrc = IMM_J;
      default:     immsrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core; stalls on mem_ready.
// Optional retired-instruction counter enabled by macro PERF_CNT_EN.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adrsrc,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             regwrite,
  output logic             memwrite,
  output logic [1:0]       alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       resultsrc,
  output logic [1:0]       aluop,
  output logic [1:0]       immsrc,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t     state, state_next;
  logic       pcupdate, branch;
  logic [1:0] imm_raw;

  imm_decoder u_imm_decoder (
    .op     (op),
    .immsrc (imm_raw)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_next;
  end

  // Outputs decode from the state register; reset_n gates them so nothing
  // strobes while reset is held even though the state already reads FETCH.
  always_comb begin
    state_next = S_FETCH;
    mem_req    = 1'b0;
    adrsrc     = 1'b0;
    irwrite    = 1'b0;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    alusrca    = SRCA_PC;
    alusrcb    = SRCB_RS2;
    resultsrc  = RES_ALUOUT;
    aluop      = ALUOP_ADD;
    illegal    = 1'b0;
    immsrc     = imm_raw;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURES;
        if (mem_ready) begin
          irwrite    = 1'b1;
          pcupdate   = 1'b1;
          state_next = S_DECODE;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            state_next = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_IMM;
        state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req    = 1'b1;
        adrsrc     = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        resultsrc  = RES_MEMDATA;
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        adrsrc     = 1'b1;
        memwrite   = 1'b1;
        state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_RS2;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_IMM;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_RS2;
        aluop      = ALUOP_SUB;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        alusrca    = SRCA_OLDPC;
        alusrcb    = SRCB_FOUR;
        pcupdate   = 1'b1;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
    pcwrite = pcupdate | (branch & zero);
    if (!reset_n) begin
      mem_req   = 1'b0;
      adrsrc    = 1'b0;
      irwrite   = 1'b0;
      pcwrite   = 1'b0;
      regwrite  = 1'b0;
      memwrite  = 1'b0;
      alusrca   = '0;
      alusrcb   = '0;
      resultsrc = '0;
      aluop     = '0;
      immsrc    = '0;
      illegal   = 1'b0;
    end
  end

`ifdef PERF_CNT_EN
  logic retire;

  // JAL retires through its ALUWB, so only the writeback states count.
  assign retire = (state == S_ALUWB) || (state == S_MEMWB) || (state == S_BEQ) ||
                  ((state == S_MEMWRITE) && mem_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller with an expected-output queue.
module tb_multicycle_controller;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [6:0]       op = 7'd0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal;
  logic [1:0]       alusrca, alusrcb, resultsrc, aluop, immsrc;
  logic [CNT_W-1:0] instret;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [CNT_W-1:0] exp_ret = '0;
  logic [16:0]      exp_q[$];
  string            tag_q[$];

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .adrsrc(adrsrc), .irwrite(irwrite), .pcwrite(pcwrite),
    .regwrite(regwrite), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .resultsrc(resultsrc), .aluop(aluop), .immsrc(immsrc), .illegal(illegal),
    .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] v(input logic mreq, adr, ir, pcw, rw, mw,
                                    input logic [1:0] sa, sb, rs, ao, im,
                                    input logic il);
    return {mreq, adr, ir, pcw, rw, mw, sa, sb, rs, ao, im, il};
  endfunction

  function automatic logic [16:0] observed();
    return {mem_req, adrsrc, irwrite, pcwrite, regwrite, memwrite,
            alusrca, alusrcb, resultsrc, aluop, immsrc, illegal};
  endfunction

  // Expected per-state outputs written straight from the state table.
  function automatic logic [16:0] s_fetch(input logic mr, input logic [1:0] im);
    return v(1, 0, mr, mr, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, im, 0);
  endfunction
  function automatic logic [16:0] s_decode(input logic [1:0] im, input logic il);
    return v(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, im, il);
  endfunction
  function automatic logic [16:0] s_memadr(input logic [1:0] im);
    return v(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, im, 0);
  endfunction
  function automatic logic [16:0] s_memread();
    return v(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0);
  endfunction
  function automatic logic [16:0] s_memwb();
    return v(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 0);
  endfunction
  function automatic logic [16:0] s_memwrite();
    return v(1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0);
  endfunction
  function automatic logic [16:0] s_exec(input logic imm_b, input logic [1:0] im);
    return v(0, 0, 0, 0, 0, 0, 2'b10, imm_b ? 2'b01 : 2'b00, 2'b00, 2'b10, im, 0);
  endfunction
  function automatic logic [16:0] s_aluwb(input logic [1:0] im);
    return v(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, 0);
  endfunction
  function automatic logic [16:0] s_beq(input logic z);
    return v(0, 0, 0, z, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 0);
  endfunction
  function automatic logic [16:0] s_jal();
    return v(0, 0, 0, 1, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 0);
  endfunction

  task automatic check_vec(input string tag, input logic [16:0] exp);
    checks++;
    assert (observed() === exp) else begin
      errors++;
      $error("FAIL %s: outputs got %h expected %h", tag, observed(), exp);
    end
  endtask

  task automatic check_ret(input string tag);
    checks++;
    assert (instret === exp_ret) else begin
      errors++;
      $error("FAIL %s_instret: got %0d expected %0d", tag, instret, exp_ret);
    end
  endtask

  // One clock: drive inputs, queue the expectation, compare at the falling edge.
  task automatic cyc(input string tag, input logic mr, input logic z,
                     input logic [16:0] exp, input logic ret);
    string t;
    logic [16:0] e;
    mem_ready = mr;
    zero = z;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_vec(t, e);
    check_ret(t);
`ifdef PERF_CNT_EN
    if (ret) exp_ret = exp_ret + 1;
`else
    if (ret) exp_ret = exp_ret;
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_hold", 17'd0);
    check_ret("reset_hold");
    reset_n = 1'b1;

    op = 7'b0000011;
    cyc("lw_fetch",   1, 0, s_fetch(1, 2'b00), 0);
    cyc("lw_decode",  1, 0, s_decode(2'b00, 0), 0);
    cyc("lw_memadr",  1, 0, s_memadr(2'b00), 0);
    cyc("lw_memread", 1, 0, s_memread(), 0);
    cyc("lw_memwb",   1, 0, s_memwb(), 1);

    op = 7'b0100011;
    cyc("sw_fetch",   1, 0, s_fetch(1, 2'b01), 0);
    cyc("sw_decode",  1, 0, s_decode(2'b01, 0), 0);
    cyc("sw_memadr",  1, 0, s_memadr(2'b01), 0);
    for (int i = 0; i < 3; i++) cyc("sw_stall", 0, 0, s_memwrite(), 0);
    cyc("sw_done",    1, 0, s_memwrite(), 1);

    op = 7'b1100011;
    cyc("beq1_fetch",  1, 1, s_fetch(1, 2'b10), 0);
    cyc("beq1_decode", 1, 1, s_decode(2'b10, 0), 0);
    cyc("beq1_taken",  1, 1, s_beq(1), 1);
    cyc("beq0_fetch",  1, 0, s_fetch(1, 2'b10), 0);
    cyc("beq0_decode", 1, 0, s_decode(2'b10, 0), 0);
    cyc("beq0_nottaken", 1, 0, s_beq(0), 1);

    op = 7'b1101111;
    cyc("jal_fetch",  1, 0, s_fetch(1, 2'b11), 0);
    cyc("jal_decode", 1, 0, s_decode(2'b11, 0), 0);
    cyc("jal_jal",    1, 0, s_jal(), 0);
    cyc("jal_aluwb",  1, 0, s_aluwb(2'b11), 1);

    op = 7'b0110011;
    cyc("r_fetch_stall", 0, 0, s_fetch(0, 2'b00), 0);
    cyc("r_fetch_stall", 0, 0, s_fetch(0, 2'b00), 0);
    cyc("r_fetch",    1, 0, s_fetch(1, 2'b00), 0);
    cyc("r_decode",   1, 0, s_decode(2'b00, 0), 0);
    cyc("r_exec",     1, 0, s_exec(0, 2'b00), 0);
    cyc("r_aluwb",    1, 0, s_aluwb(2'b00), 1);

    op = 7'b0010011;
    cyc("i_fetch",    1, 0, s_fetch(1, 2'b00), 0);
    cyc("i_decode",   1, 0, s_decode(2'b00, 0), 0);
    cyc("i_exec",     1, 0, s_exec(1, 2'b00), 0);
    cyc("i_aluwb",    1, 0, s_aluwb(2'b00), 1);

    op = 7'b1111111;
    cyc("ill_fetch",  1, 0, s_fetch(1, 2'b00), 0);
    cyc("ill_decode", 1, 0, s_decode(2'b00, 1), 0);
    cyc("ill_refetch", 0, 0, s_fetch(0, 2'b00), 0);

    op = 7'b0100011;
    cyc("rst_fetch",  1, 0, s_fetch(1, 2'b01), 0);
    cyc("rst_decode", 1, 0, s_decode(2'b01, 0), 0);
    cyc("rst_memadr", 0, 0, s_memadr(2'b01), 0);
    cyc("rst_memwrite", 0, 0, s_memwrite(), 0);
    reset_n = 1'b0;
    exp_ret = '0;
    #1;
    check_vec("rst_async", 17'd0);
    check_ret("rst_async");
    @(negedge clk);
    reset_n = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc("rst_after",  0, 0, s_fetch(0, 2'b01), 0);
    cyc("rst_after2", 1, 0, s_fetch(1, 2'b01), 0);
    cyc("rst_decode2", 1, 0, s_decode(2'b01, 0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle variant of the RV32I core.
- Sequences the shared ALU, register file, unified memory and immediate extender across fetch, decode, execute, memory and writeback states.
- Drives `immsrc` to the immediate extender and all datapath mux selects and write strobes.
- Stalls on a memory ready handshake.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  7  `instr[6:0]` from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALU result.
- irwrite  out  1  instruction register load.
- pcwrite  out  1  PC load.
- regwrite  out  1  register file write.
- memwrite  out  1  memory write.
- alusrca  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1.
- alusrcb  out  2  ALU B select: 00 = rs2, 01 = immext, 10 = constant 4.
- resultsrc  out  2  result select: 00 = ALU out register, 01 = mem data, 10 = ALU result.
- aluop  out  2  to ALU decoder: 00 = add, 01 = sub, 10 = funct decode.
- immsrc  out  2  to immediate extender: 00 = I, 01 = S, 10 = B, 11 = J.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- instret  out  CNT_W  retired instruction count.

Behaviour:
- State register updates on posedge clk; reset_n low forces state FETCH asynchronously.
- While reset_n is low: mem_req, irwrite, pcwrite, regwrite, memwrite, illegal = 0; instret = 0; all selects = 0.
- `immsrc` is combinational from op in every state:
  - lw / I-ALU → 00; sw → 01; beq → 10; jal → 11; others → 00.
- States, outputs not listed = 0, and transitions:
  - FETCH: mem_req=1, adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10. When mem_ready: irwrite=1, pcupdate=1, go to DECODE. Otherwise stay, with no strobes.
  - DECODE: alusrca=01, alusrcb=01, aluop=00 (branch target). Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - else → FETCH with illegal=1 for this cycle.
  - MEMADR: alusrca=10, alusrcb=01, aluop=00. Go to MEMREAD if op=lw, else MEMWRITE.
  - MEMREAD: mem_req=1, adrsrc=1, resultsrc=00. Go to MEMWB on mem_ready, else hold.
  - MEMWB: resultsrc=01, regwrite=1. Go to FETCH.
  - MEMWRITE: mem_req=1, adrsrc=1, memwrite=1, resultsrc=00. Go to FETCH on mem_ready, else hold with memwrite still high.
  - EXECUTER: alusrca=10, alusrcb=00, aluop=10. Go to ALUWB.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=10. Go to ALUWB.
  - ALUWB: resultsrc=00, regwrite=1. Go to FETCH.
  - BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1. Go to FETCH.
  - JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1. Go to ALUWB.
- pcwrite = pcupdate | (branch & zero). Internal pcupdate and branch are not ports.
- Latencies in cycles, excluding stalls: lw 5, sw 4, R/I 4, beq 3, jal 4.
- Each mem_ready-low cycle in FETCH, MEMREAD or MEMWRITE adds exactly 1 cycle.
- mem_ready high outside these states is ignored.
- Undefined state encodings recover to FETCH on the next clock.
- reset_n falling mid-instruction aborts the instruction; no write strobe is emitted after reset deasserts until the next legal state.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined: instret increments by 1, wrapping at 2^CNT_W, on every retiring cycle:
  - ALUWB, MEMWB, BEQ;
  - MEMWRITE with mem_ready.
  - JAL retires through its ALUWB, so it is counted once.
- Not defined: instret is tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package `riscv_pkg` holds:
  - the state enum;
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL;
  - IMM_I/S/B/J, ALUOP_*, SRCA_*, SRCB_*, RES_* encodings.
- One sub-module, `imm_decoder`: pure combinational op → immsrc.
  - The extender gains the 11 = J case under the same package constants.

Test Plan:
- reset_n low mid-MEMWRITE, mem_ready=0 → all strobes 0 immediately. After release: state FETCH, mem_req=1, instret=0.
- op=0000011, mem_ready always 1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. regwrite=1 only in cycle 5; immsrc=00.
- op=0100011, mem_ready low for 3 cycles in MEMWRITE → memwrite held high 4 cycles, then FETCH; immsrc=01; regwrite never high.
- op=1100011, zero=1 then rerun with zero=0 → pcwrite high in cycle 3 only when zero=1; immsrc=10; aluop=01.
- op=1101111 → pcwrite=1 in JAL state, regwrite=1 in the following ALUWB, immsrc=11. With PERF_CNT_EN, instret +1.
- op=1111111 → illegal=1 for 1 cycle in DECODE, next state FETCH, no regwrite/memwrite, instret unchanged.
